// File: rtl/sha_msg_arbiter.sv
// rtl/sha_msg_arbiter.sv - rotating-priority arbiter muxing N message requesters onto one SHA message builder
module sha_msg_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     i_sync_rst,
    input  logic [64*NUM_REQ-1:0]    i_req_cfg_size,
    input  logic [NUM_REQ-1:0]       i_req_cfg_valid,
    output logic [NUM_REQ-1:0]       o_req_cfg_ready,
    input  logic [512*NUM_REQ-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]       i_req_data_last,
    input  logic [NUM_REQ-1:0]       i_req_data_valid,
    output logic [NUM_REQ-1:0]       o_req_data_ready,
    output logic [63:0]              o_mb_cfg_size,
    output logic [ID_W-1:0]          o_mb_cfg_id,
    output logic                     o_mb_cfg_valid,
    input  logic                     i_mb_cfg_ready,
    output logic [511:0]             o_mb_data,
    output logic                     o_mb_data_last,
    output logic                     o_mb_data_valid,
    input  logic                     i_mb_data_ready,
    output logic                     o_busy,
    output logic                     o_err_len
);

    typedef enum logic [1:0] {ST_IDLE, ST_CFG, ST_DATA, ST_DONE} state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_gnt;
    logic [54:0]       r_beats_rem;
    logic [63:0]       r_mb_cfg_size;
    logic              r_mb_cfg_valid;
    logic [511:0]      r_mb_data;
    logic              r_mb_data_last;
    logic              r_mb_data_valid;
    logic              r_err_len;

    logic              w_gnt_found;
    logic [ID_W-1:0]   w_gnt_idx;
    logic [63:0]       w_sel_size;
    logic [54:0]       w_sel_beats;
    logic              w_dn_free;
    logic              w_data_rdy;
    logic              w_data_hs;
    logic              w_sel_last;
    logic              w_dn_hs;
    logic [ID_W-1:0]   w_next_ptr;

    // Rotating priority: scan from the far end so the lowest offset from rr_ptr wins last.
    always_comb begin
        logic [ID_W-1:0] v_idx;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        v_idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            v_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (i_req_cfg_valid[v_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = v_idx;
            end
        end
    end

    assign w_sel_size  = i_req_cfg_size[64*w_gnt_idx +: 64];
    assign w_sel_beats = (w_sel_size == 64'd0) ? 55'd1
                       : w_sel_size[63:9] + {54'd0, |w_sel_size[8:0]};

    assign w_dn_free  = !r_mb_data_valid || i_mb_data_ready;
    assign w_data_rdy = (r_state == ST_DATA) && w_dn_free && (r_beats_rem != 55'd0);
    assign w_data_hs  = w_data_rdy && i_req_data_valid[r_gnt];
    assign w_sel_last = i_req_data_last[r_gnt];
    assign w_dn_hs    = r_mb_data_valid && i_mb_data_ready;
    assign w_next_ptr = (r_gnt == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;

    // Config ready only toward the requester being granted this cycle.
    always_comb begin
        o_req_cfg_ready = '0;
        if ((r_state == ST_IDLE) && w_gnt_found) begin
            o_req_cfg_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Data ready only toward the owner, and only while the output register can take a beat.
    always_comb begin
        o_req_data_ready = '0;
        if (w_data_rdy) begin
            o_req_data_ready[r_gnt] = 1'b1;
        end
    end

    // Ownership FSM plus the registered config and data output stages.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state         <= ST_IDLE;
            r_rr_ptr        <= '0;
            r_gnt           <= '0;
            r_beats_rem     <= '0;
            r_mb_cfg_size   <= '0;
            r_mb_cfg_valid  <= 1'b0;
            r_mb_data       <= '0;
            r_mb_data_last  <= 1'b0;
            r_mb_data_valid <= 1'b0;
            r_err_len       <= 1'b0;
        end else if (i_sync_rst) begin
            r_state         <= ST_IDLE;
            r_rr_ptr        <= '0;
            r_gnt           <= '0;
            r_beats_rem     <= '0;
            r_mb_cfg_size   <= '0;
            r_mb_cfg_valid  <= 1'b0;
            r_mb_data       <= '0;
            r_mb_data_last  <= 1'b0;
            r_mb_data_valid <= 1'b0;
            r_err_len       <= 1'b0;
        end else begin
            r_err_len <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_found) begin
                        r_gnt          <= w_gnt_idx;
                        r_mb_cfg_size  <= w_sel_size;
                        r_mb_cfg_valid <= 1'b1;
                        r_beats_rem    <= w_sel_beats;
                        r_state        <= ST_CFG;
                    end
                end
                ST_CFG: begin
                    if (i_mb_cfg_ready) begin
                        r_mb_cfg_valid <= 1'b0;
                        r_state        <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_data_hs) begin
                        // The beat counter decides framing; a disagreeing last flag is only flagged.
                        r_mb_data       <= i_req_data[512*r_gnt +: 512];
                        r_mb_data_valid <= 1'b1;
                        r_mb_data_last  <= (r_beats_rem == 55'd1);
                        r_beats_rem     <= r_beats_rem - 55'd1;
                        r_err_len       <= (w_sel_last != (r_beats_rem == 55'd1));
                        if (r_beats_rem == 55'd1) begin
                            r_state <= ST_DONE;
                        end
                    end else if (w_dn_hs) begin
                        r_mb_data_valid <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (w_dn_hs) begin
                        r_mb_data_valid <= 1'b0;
                        if (r_mb_data_last) begin
                            r_rr_ptr <= w_next_ptr;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_mb_cfg_size   = r_mb_cfg_size;
    assign o_mb_cfg_id     = r_gnt;
    assign o_mb_cfg_valid  = r_mb_cfg_valid;
    assign o_mb_data       = r_mb_data;
    assign o_mb_data_last  = r_mb_data_last;
    assign o_mb_data_valid = r_mb_data_valid;
    assign o_busy          = (r_state != ST_IDLE);
    assign o_err_len       = r_err_len;

endmodule

// File: doc/sha_msg_arbiter.md
SHA_MSG_ARBITER -- requirements
Module: sha_msg_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one message builder (legal 2..8); ID_W = clog2(NUM_REQ).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 nrst  input  1  asynchronous, active-low reset.
REQ-004 sync_rst  input  1  synchronous localised reset, same effect as nrst.
REQ-005 req_cfg_size  input  64*NUM_REQ  per-requester message size in bits, requester i at [64i+63:64i].
REQ-006 req_cfg_valid / req_cfg_ready  input / output  NUM_REQ  per-requester config handshake.
REQ-007 req_data  input  512*NUM_REQ  per-requester data word, requester i at [512i+511:512i].
REQ-008 req_data_last / req_data_valid / req_data_ready  input / input / output  NUM_REQ  per-requester data handshake.
REQ-009 mb_cfg_size / mb_cfg_id / mb_cfg_valid / mb_cfg_ready  output 64 / output ID_W / output 1 / input 1  config channel to message builder.
REQ-010 mb_data / mb_data_last / mb_data_valid / mb_data_ready  output 512 / output 1 / output 1 / input 1  data channel to message builder.
REQ-011 busy  output  1  high whenever a message is granted.
REQ-012 err_len  output  1  one-cycle pulse on req_data_last/beat-count mismatch.

Function
REQ-013 FSM states: IDLE, CFG, DATA, DONE; exactly one message owns the builder from grant until its last data word handshakes downstream.
REQ-014 IDLE: if any req_cfg_valid, grant g = first valid requester at or after rr_ptr (rotating priority, wrap NUM_REQ-1 -> 0); same cycle: req_cfg_ready[g]=1 (others 0), capture size, id, beats; next state CFG.
REQ-015 req_cfg_ready SHALL be combinational, high only in IDLE for the granted index; never high for two requesters.
REQ-016 beats = size[63:9] + (|size[8:0]), forced to 1 when size=0; 55-bit counter beats_rem.
REQ-017 CFG: mb_cfg_valid=1 with registered mb_cfg_size/mb_cfg_id, held stable until mb_cfg_ready; on handshake, mb_cfg_valid drops next cycle, state DATA.
REQ-018 DATA: req_data_ready[g] = (!mb_data_valid || mb_data_ready) && beats_rem!=0; all other req_data_ready = 0.
REQ-019 On req_data handshake: mb_data <= req_data[g], mb_data_valid <= 1, mb_data_last <= (beats_rem==1), beats_rem decrements; latency 1 cycle, full throughput.
REQ-020 mb_data_valid cleared when downstream handshakes and no new beat is loaded in that cycle; mb_data/mb_data_last held stable while valid && !ready.
REQ-021 Beat count is authoritative: err_len pulses if req_data_last=1 with beats_rem!=1, or req_data_last=0 with beats_rem==1; forwarding unchanged.
REQ-022 After final beat accepted, state DONE; on mb_data_valid && mb_data_ready && mb_data_last: rr_ptr <= (g+1) mod NUM_REQ, state IDLE.
REQ-023 busy = (state != IDLE); no new grant until DONE completes.
REQ-024 Requester dropping req_cfg_valid after IDLE grant is irrelevant (config captured at grant).

Reset
REQ-025 On nrst low (async) or sync_rst high at clk edge: state IDLE, rr_ptr 0, beats_rem 0, all outputs 0 (mb_data 512'd0, mb_cfg_size 64'd0, err_len 0, busy 0).
REQ-026 Reset mid-message abandons it; no partial output after release; first grant after reset uses rr_ptr 0.

Verification
REQ-027 Single requester 0, size=1000 -> mb_cfg_size=1000, id=0; two data beats forwarded, second with mb_data_last=1; busy falls after last handshake.
REQ-028 All four cfg_valid asserted continuously, size=512 each -> grant order 0,1,2,3,0; each message exactly one beat with last=1.
REQ-029 size=0 from requester 2 -> one beat forwarded, mb_data_last=1, mb_cfg_id=2.
REQ-030 mb_data_ready held low 5 cycles mid-message, size=1536 -> mb_data stable, req_data_ready[g]=0, no beat lost or duplicated, 3 beats total.
REQ-031 size=1024 with req_data_last=1 on first beat -> err_len pulses one cycle; second beat still accepted and marked last.
REQ-032 nrst asserted during DATA of a 4-beat message -> outputs zero immediately; after release, new request granted from requester 0 normally.
